demux_l1_sched: RTL and testbench

Credit-based lane scheduler for the L1 2-to-4 byte demultiplexer. Each `clk_2f` cycle it assigns the two incoming L1 byte streams to distinct output lanes 0..3 in round-robin order. It only assigns a lane whose downstream FIFO has advertised free space. It tracks per-lane credits returned by the downstream FIFOs and drives the lane selects and accept strobes that steer the demux datapath.

---
 rtl/demux_l1_sched_pkg.sv | 10 +
 rtl/demux_l1_sched_if.sv | 13 +
 rtl/demux_l1_sched_rr_pick4.sv | 25 ++
 rtl/demux_l1_sched.sv | 74 +++++++
 tb/tb_demux_l1_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_l1_sched_pkg.sv
// Shared types and widths for the L1 2-to-4 demux lane scheduler.
package demux_l1_sched_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int CNT_W     = 3;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} st_e;
  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/demux_l1_sched_if.sv
// Upstream request/grant handshake between the L1 byte inputs and the scheduler.
interface demux_l1_sched_if;
  import demux_l1_sched_pkg::*;
  logic  valid1;
  logic  valid2;
  logic  grant0;
  logic  grant1;
  lane_t sel0;
  lane_t sel1;

  modport master (output valid1, valid2, input grant0, grant1, sel0, sel1);
  modport slave  (input valid1, valid2, output grant0, grant1, sel0, sel1);
endinterface

// File: rtl/demux_l1_sched_rr_pick4.sv
// Round-robin finder: first set bit of mask scanning upward from start, modulo 4.
module rr_pick4
  import demux_l1_sched_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  input  lane_t                start,
  output logic                 found,
  output lane_t                lane
);
  lane_t idx;

  // Scan from the far end so the lane closest to start overrides the rest.
  always_comb begin
    found = 1'b0;
    lane  = '0;
    idx   = '0;
    for (int k = NUM_LANES-1; k >= 0; k--) begin
      idx = start + lane_t'(k);
      if (mask[idx]) begin
        found = 1'b1;
        lane  = idx;
      end
    end
  end
endmodule

// File: rtl/demux_l1_sched.sv
// Credit-based round-robin lane scheduler steering two L1 byte inputs onto four lanes.
module demux_l1_sched
  import demux_l1_sched_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                 clk_2f,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [NUM_LANES-1:0] credit_ret,
  demux_l1_sched_if.slave      bus,
  output logic [NUM_LANES-1:0] lane_avail,
  output logic                 err_overflow,
  output logic                 active
);
  st_e                             state;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt, cnt_nxt;
  lane_t                           rr_ptr;
  logic [NUM_LANES-1:0]            elig, mask1, take, ovf;
  logic                            found0, found1, g0, g1;
  lane_t                           lane0, lane1, start1;

  // Input 1 never reuses input 0's lane; with no input-0 request it starts at rr_ptr.
  assign mask1  = bus.valid1 ? (elig & ~(NUM_LANES'(1) << lane0)) : elig;
  assign start1 = bus.valid1 ? lane_t'(lane0 + 1'b1) : rr_ptr;

  rr_pick4 u_pick0 (.mask(elig),  .start(rr_ptr), .found(found0), .lane(lane0));
  rr_pick4 u_pick1 (.mask(mask1), .start(start1), .found(found1), .lane(lane1));

  assign g0 = (state == ST_ACTIVE) && bus.valid1 && found0;
  assign g1 = (state == ST_ACTIVE) && bus.valid2 && found1;

  assign bus.grant0 = g0;
  assign bus.grant1 = g1;
  assign bus.sel0   = g0 ? lane0 : '0;
  assign bus.sel1   = g1 ? lane1 : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign elig[i] = |cnt[i];
    assign take[i] = (g0 && lane0 == lane_t'(i)) || (g1 && lane1 == lane_t'(i));
    // A return to a full lane with no grant is dropped rather than wrapped.
    assign ovf[i]  = credit_ret[i] && !take[i] && (cnt[i] == cnt_t'(CREDITS));
    assign cnt_nxt[i] = ovf[i] ? cnt[i]
                               : cnt[i] - cnt_t'(take[i]) + cnt_t'(credit_ret[i]);
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_LANES; i++) cnt[i] <= cnt_t'(CREDITS);
      lane_avail   <= '1;
      err_overflow <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      cnt <= cnt_nxt;
      for (int i = 0; i < NUM_LANES; i++) lane_avail[i] <= |cnt_nxt[i];
      if (|ovf) err_overflow <= 1'b1;
      if (g1)      rr_ptr <= lane1 + 1'b1;
      else if (g0) rr_ptr <= lane0 + 1'b1;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state  <= ST_IDLE;
      active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (enable)  begin state <= ST_ACTIVE; active <= 1'b1; end
        ST_ACTIVE: if (!enable) begin state <= ST_IDLE;   active <= 1'b0; end
        default:   begin state <= ST_IDLE; active <= 1'b0; end
      endcase
    end
  end
endmodule

// File: tb/tb_demux_l1_sched.sv
// Self-checking bench for demux_l1_sched: directed scenarios plus randomized traffic vs a credit model.
module tb_demux_l1_sched;
  import demux_l1_sched_pkg::*;
  localparam int CREDITS = 4;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] credit_ret = 4'b0;
  logic [3:0] lane_avail;
  logic       err_overflow, active;

  demux_l1_sched_if bus();

  demux_l1_sched #(.CREDITS(CREDITS)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .enable(enable), .credit_ret(credit_ret),
    .bus(bus.slave), .lane_avail(lane_avail), .err_overflow(err_overflow), .active(active)
  );

  always #5 clk_2f = ~clk_2f;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: credit counts, pointer, mode, sticky error.
  int   m_cnt [4];
  int   m_ptr;
  bit   m_act, m_err;
  bit   e_g0, e_g1;
  int   e_s0, e_s1;
  bit   c_en;
  logic [3:0] c_ret;

  function automatic logic [3:0] m_avail();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = (m_cnt[i] > 0);
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = CREDITS;
    m_ptr = 0; m_act = 0; m_err = 0;
  endtask

  // Drive one cycle's inputs and predict the grants from the model state.
  task automatic apply(input bit en, input bit v1, input bit v2, input logic [3:0] ret);
    int start, ln;
    enable = en; bus.valid1 = v1; bus.valid2 = v2; credit_ret = ret;
    c_en = en; c_ret = ret;
    e_g0 = 0; e_s0 = 0; e_g1 = 0; e_s1 = 0;
    if (m_act && v1)
      for (int k = 0; k < 4; k++) begin
        ln = (m_ptr + k) % 4;
        if (!e_g0 && m_cnt[ln] > 0) begin e_g0 = 1; e_s0 = ln; end
      end
    if (m_act && v2) begin
      start = v1 ? (e_s0 + 1) % 4 : m_ptr;
      for (int k = 0; k < 4; k++) begin
        ln = (start + k) % 4;
        if (!e_g1 && m_cnt[ln] > 0 && !(e_g0 && ln == e_s0)) begin e_g1 = 1; e_s1 = ln; end
      end
    end
    #3;
  endtask

  task automatic tick();
    bit g;
    @(posedge clk_2f);
    for (int i = 0; i < 4; i++) begin
      g = (e_g0 && e_s0 == i) || (e_g1 && e_s1 == i);
      if (c_ret[i] && !g && m_cnt[i] == CREDITS) m_err = 1;
      else m_cnt[i] = m_cnt[i] - int'(g) + int'(c_ret[i]);
    end
    if (e_g1)      m_ptr = (e_s1 + 1) % 4;
    else if (e_g0) m_ptr = (e_s0 + 1) % 4;
    m_act = c_en;
    #1;
  endtask

  task automatic hard_reset();
    reset_L = 1'b0; enable = 0; bus.valid1 = 0; bus.valid2 = 0; credit_ret = 0;
    @(posedge clk_2f); #1;
    reset_L = 1'b1;
    model_reset();
  endtask

  // Both inputs valid for n cycles; returns the number of grants seen.
  task automatic run_both(input int n, output int total, output int per [4]);
    total = 0;
    for (int i = 0; i < 4; i++) per[i] = 0;
    for (int c = 0; c < n; c++) begin
      apply(1, 1, 1, 4'b0);
      if (bus.grant0) begin total++; per[bus.sel0]++; end
      if (bus.grant1) begin total++; per[bus.sel1]++; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0; enable = 1; bus.valid1 = 1; bus.valid2 = 1; credit_ret = 0;
    @(posedge clk_2f); #2;
    n_tests++; if ({bus.grant0, bus.grant1} !== 2'b00) begin n_fail++; $display("FAIL reset_grants: got %b want 00", {bus.grant0, bus.grant1}); end
    n_tests++; if ({bus.sel0, bus.sel1} !== 4'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0000", {bus.sel0, bus.sel1}); end
    n_tests++; if (lane_avail !== 4'b1111) begin n_fail++; $display("FAIL reset_lane_avail: got %b want 1111", lane_avail); end
    n_tests++; if ({err_overflow, active} !== 2'b00) begin n_fail++; $display("FAIL reset_err_active: got %b want 00", {err_overflow, active}); end
    reset_L = 1'b1; enable = 0; bus.valid1 = 0; bus.valid2 = 0;
    model_reset();
  endtask

  task automatic test_rr_order();
    hard_reset();
    apply(1, 0, 0, 4'b0);
    n_tests++; if (bus.grant0 !== 1'b0) begin n_fail++; $display("FAIL idle_no_grant: got %b want 0", bus.grant0); end
    tick();
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL active_after_enable: got %b want 1", active); end
    apply(1, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.grant1, bus.sel0, bus.sel1} !== 6'b11_00_01) begin n_fail++; $display("FAIL rr_cycle1: got %b want 110001", {bus.grant0, bus.grant1, bus.sel0, bus.sel1}); end
    tick();
    apply(1, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.grant1, bus.sel0, bus.sel1} !== 6'b11_10_11) begin n_fail++; $display("FAIL rr_cycle2: got %b want 111011", {bus.grant0, bus.grant1, bus.sel0, bus.sel1}); end
    tick();
    apply(1, 1, 0, 4'b0);
    n_tests++; if ({bus.grant0, bus.sel0} !== 3'b1_00) begin n_fail++; $display("FAIL rr_ptr_wrap: got %b want 100", {bus.grant0, bus.sel0}); end
  endtask

  task automatic test_exhaust();
    int total; int per [4];
    hard_reset();
    apply(1, 0, 0, 4'b0); tick();
    run_both(8, total, per);
    n_tests++; if (total !== 16) begin n_fail++; $display("FAIL exhaust_total: got %0d want 16", total); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (per[i] !== 4) begin n_fail++; $display("FAIL exhaust_lane%0d: got %0d want 4", i, per[i]); end
    end
    apply(1, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.grant1} !== 2'b00) begin n_fail++; $display("FAIL exhaust_cycle9_grants: got %b want 00", {bus.grant0, bus.grant1}); end
    n_tests++; if (lane_avail !== 4'b0000) begin n_fail++; $display("FAIL exhaust_lane_avail: got %b want 0000", lane_avail); end
    tick();
  endtask

  task automatic test_single_lane();
    apply(1, 0, 0, 4'b0001); tick();
    apply(1, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.sel0, bus.grant1} !== 4'b1_00_0) begin n_fail++; $display("FAIL single_lane0: got %b want 1000", {bus.grant0, bus.sel0, bus.grant1}); end
    tick();
    apply(1, 1, 1, 4'b0100);
    n_tests++; if ({bus.grant0, bus.grant1} !== 2'b00) begin n_fail++; $display("FAIL no_bypass: got %b want 00", {bus.grant0, bus.grant1}); end
    tick();
    apply(1, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.sel0, bus.grant1} !== 4'b1_10_0) begin n_fail++; $display("FAIL single_lane2: got %b want 1100", {bus.grant0, bus.sel0, bus.grant1}); end
    tick();
  endtask

  task automatic test_simul();
    apply(1, 0, 0, 4'b0001); tick();
    apply(1, 1, 0, 4'b0001);
    n_tests++; if ({bus.grant0, bus.sel0} !== 3'b1_00) begin n_fail++; $display("FAIL simul_grant: got %b want 100", {bus.grant0, bus.sel0}); end
    tick();
    n_tests++; if (lane_avail !== 4'b0001) begin n_fail++; $display("FAIL simul_avail: got %b want 0001", lane_avail); end
    apply(1, 1, 0, 4'b0);
    n_tests++; if ({bus.grant0, bus.sel0} !== 3'b1_00) begin n_fail++; $display("FAIL simul_count_held: got %b want 100", {bus.grant0, bus.sel0}); end
    tick();
    n_tests++; if (lane_avail !== 4'b0000) begin n_fail++; $display("FAIL simul_drained: got %b want 0000", lane_avail); end
  endtask

  task automatic test_overflow();
    int total; int per [4];
    hard_reset();
    apply(0, 0, 0, 4'b0100); tick();
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", err_overflow); end
    apply(1, 0, 0, 4'b0); tick();
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
    run_both(8, total, per);
    n_tests++; if (per[2] !== CREDITS) begin n_fail++; $display("FAIL ovf_lane2_count: got %0d want %0d", per[2], CREDITS); end
    n_tests++; if (lane_avail !== 4'b0000) begin n_fail++; $display("FAIL ovf_drained: got %b want 0000", lane_avail); end
  endtask

  task automatic test_idle_reset();
    int total; int per [4];
    hard_reset();
    apply(1, 0, 0, 4'b0); tick();
    apply(1, 1, 1, 4'b0); tick();
    apply(0, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.grant1, bus.sel0, bus.sel1} !== 6'b11_10_11) begin n_fail++; $display("FAIL disable_edge_grants: got %b want 111011", {bus.grant0, bus.grant1, bus.sel0, bus.sel1}); end
    tick();
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b want 0", active); end
    apply(0, 1, 1, 4'b1111);
    n_tests++; if ({bus.grant0, bus.grant1} !== 2'b00) begin n_fail++; $display("FAIL idle_grants: got %b want 00", {bus.grant0, bus.grant1}); end
    tick();
    n_tests++; if ({lane_avail, err_overflow} !== 5'b1111_0) begin n_fail++; $display("FAIL idle_returns: got %b want 11110", {lane_avail, err_overflow}); end
    apply(1, 0, 0, 4'b0001); tick();
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL idle_full_ovf: got %b want 1", err_overflow); end
    apply(1, 1, 1, 4'b0);
    n_tests++; if ({bus.grant0, bus.grant1} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_grants: got %b want 11", {bus.grant0, bus.grant1}); end
    #1 reset_L = 1'b0;
    #1;
    n_tests++; if ({bus.grant0, bus.grant1} !== 2'b00) begin n_fail++; $display("FAIL midreset_grants: got %b want 00", {bus.grant0, bus.grant1}); end
    n_tests++; if ({lane_avail, err_overflow, active} !== 6'b1111_00) begin n_fail++; $display("FAIL midreset_state: got %b want 111100", {lane_avail, err_overflow, active}); end
    @(posedge clk_2f); #1;
    reset_L = 1'b1;
    model_reset();
    apply(1, 0, 0, 4'b0); tick();
    run_both(8, total, per);
    n_tests++; if (total !== 4 * CREDITS) begin n_fail++; $display("FAIL midreset_credits: got %0d want %0d", total, 4 * CREDITS); end
  endtask

  task automatic test_random();
    bit en, v1, v2;
    logic [3:0] ret;
    hard_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      v1 = $urandom_range(0, 1) == 1;
      v2 = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 4; i++) ret[i] = ($urandom_range(0, 2) == 0);
      apply(en, v1, v2, ret);
      n_tests++; if ({bus.grant0, bus.grant1} !== {e_g0, e_g1}) begin n_fail++; $display("FAIL rand_grants c%0d: got %b want %b", c, {bus.grant0, bus.grant1}, {e_g0, e_g1}); end
      if (e_g0) begin
        n_tests++; if (int'(bus.sel0) !== e_s0) begin n_fail++; $display("FAIL rand_sel0 c%0d: got %0d want %0d", c, bus.sel0, e_s0); end
      end
      if (e_g1) begin
        n_tests++; if (int'(bus.sel1) !== e_s1) begin n_fail++; $display("FAIL rand_sel1 c%0d: got %0d want %0d", c, bus.sel1, e_s1); end
      end
      tick();
      n_tests++; if ({lane_avail, active, err_overflow} !== {m_avail(), m_act, m_err}) begin n_fail++; $display("FAIL rand_regs c%0d: got %b want %b", c, {lane_avail, active, err_overflow}, {m_avail(), m_act, m_err}); end
    end
  endtask

  initial begin
    bus.valid1 = 1'b0;
    bus.valid2 = 1'b0;
    model_reset();
    test_reset();
    test_rr_order();
    test_exhaust();
    test_single_lane();
    test_simul();
    test_overflow();
    test_idle_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
